// File: rtl/msrr_pkg.sv
// Shared definitions for the multi-mode shift/rotate register:
// operation codes, FSM state encoding and a small mode classifier.
package msrr_pkg;

    // Operation select, one step per code.
    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_SHR  = 3'b001;
    localparam mode_t MODE_ROR  = 3'b010;
    localparam mode_t MODE_SHR2 = 3'b011;
    localparam mode_t MODE_SHL  = 3'b100;
    localparam mode_t MODE_ROL  = 3'b101;
    localparam mode_t MODE_ASR  = 3'b110;
    localparam mode_t MODE_LOAD = 3'b111;

    // Sequencer states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Hold and load are idempotent: repeating them gains nothing, so a
    // start request with either code completes in a single cycle.
    function automatic logic is_single_shot(input mode_t m);
        return (m == MODE_HOLD) || (m == MODE_LOAD);
    endfunction

endpackage

// File: rtl/msrr_param_if.sv
// Control/data bundle of the shift/rotate register. The master drives the
// operation request side; the slave (the register) returns contents,
// serial taps and the busy/done handshake.
interface msrr_param_if
    import msrr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic              inz;
    logic              en;
    mode_t             mode;
    logic              sIn;
    logic              sIn_l;
    logic [WIDTH-1:0]  d_in;
    logic              start;
    logic [CNT_W-1:0]  amt;
    logic [WIDTH-1:0]  Q;
    logic              sOut_r;
    logic              sOut_l;
    logic              busy;
    logic              done;

    modport master (
        output inz, en, mode, sIn, sIn_l, d_in, start, amt,
        input  Q, sOut_r, sOut_l, busy, done
    );

    modport slave (
        input  inz, en, mode, sIn, sIn_l, d_in, start, amt,
        output Q, sOut_r, sOut_l, busy, done
    );
endinterface

// File: rtl/msrr_step.sv
// Single-step next-value function of the shift/rotate register.
// Purely combinational: given the current contents, an operation code and
// the serial/parallel inputs, it returns the contents after one step.
module msrr_step
    import msrr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  mode_t            mode_i,
    input  logic             s_in,
    input  logic             s_in_l,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_next
);

    // Two-place right shift; a 2-bit register is simply refilled from sIn,
    // which keeps the upper slice from going out of range at WIDTH = 2.
    logic [WIDTH-1:0] shr2_s;

    generate
        if (WIDTH > 2) begin : g_shr2_wide
            assign shr2_s = {s_in, s_in, q_i[WIDTH-1:2]};
        end else begin : g_shr2_narrow
            assign shr2_s = {s_in, s_in};
        end
    endgenerate

    // Decode the operation and form the one-step result.
    always_comb begin
        q_next = q_i;
        case (mode_i)
            MODE_HOLD: q_next = q_i;
            MODE_SHR:  q_next = {s_in, q_i[WIDTH-1:1]};
            MODE_ROR:  q_next = {q_i[0], q_i[WIDTH-1:1]};
            MODE_SHR2: q_next = shr2_s;
            MODE_SHL:  q_next = {q_i[WIDTH-2:0], s_in_l};
            MODE_ROL:  q_next = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ASR:  q_next = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            MODE_LOAD: q_next = d_in;
            default:   q_next = q_i;
        endcase
    end

endmodule

// File: rtl/msrr_param.sv
// Parametrised multi-mode shift/rotate register with a multi-step engine.
// Single steps are issued with en; a start strobe repeats the latched
// operation amt times, reporting progress with busy and completion with a
// one-cycle done pulse. inz reinitialises the register from any state.
module msrr_param
    import msrr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = $clog2(WIDTH) + 1,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic        clk,
    input  logic        Re,
    msrr_param_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Register contents, latched operation, remaining steps, state, done.
    logic [WIDTH-1:0] q_q,     q_d;
    mode_t            op_q,    op_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [0:0]       state_q, state_d;
    logic             done_q,  done_d;

    // Step function input selection and result.
    mode_t            step_mode_s;
    logic [WIDTH-1:0] step_q_s;

    // While running, the latched operation drives the step; the live mode
    // input is ignored so the caller may change it freely.
    assign step_mode_s = (state_q == ST_RUN) ? op_q : bus.mode;

    msrr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i    (q_q),
        .mode_i (step_mode_s),
        .s_in   (bus.sIn),
        .s_in_l (bus.sIn_l),
        .d_in   (bus.d_in),
        .q_next (step_q_s)
    );

    // Next-state logic: inz, then a running step, then start, then en.
    always_comb begin
        q_d     = q_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        done_d  = 1'b0;
        if (bus.inz) begin
            // Reinitialise; any operation in flight is dropped silently.
            q_d     = INIT;
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    q_d   = step_q_s;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        // Last step applied now; report it next cycle.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_IDLE: begin
                    if (bus.start) begin
                        op_d  = bus.mode;
                        cnt_d = bus.amt;
                        if (is_single_shot(bus.mode) || (bus.amt == CNT_ZERO)) begin
                            // Completes at once: only a load changes Q.
                            if (bus.mode == MODE_LOAD) begin
                                q_d = bus.d_in;
                            end else begin
                                q_d = q_q;
                            end
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (bus.en) begin
                        q_d = step_q_s;
                    end else begin
                        q_d = q_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge Re) begin
        if (Re) begin
            q_q     <= {WIDTH{1'b0}};
            op_q    <= MODE_HOLD;
            cnt_q   <= CNT_ZERO;
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from flops; done is only set on the way out of
    // RUN (or from IDLE), so it can never coincide with busy.
    assign bus.Q      = q_q;
    assign bus.sOut_r = q_q[0];
    assign bus.sOut_l = q_q[WIDTH-1];
    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = done_q;

endmodule
